// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and bubble outputs.
// Define PIPE_SKID_EN for the two-entry skid build with registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic              vld_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] hd_wd_q;
  logic              hd_wreg_q;
  logic [DATA_W-1:0] hd_wdata_q;

  logic acc;
  logic rel;

`ifdef PIPE_SKID_EN
  logic              rdy_q;
  logic [ADDR_W-1:0] sk_wd_q;
  logic              sk_wreg_q;
  logic [DATA_W-1:0] sk_wdata_q;

  assign in_ready = rdy_q;
`else
  // Single entry: a release frees the slot in the same cycle.
  assign in_ready = ~vld_q | out_ready;
`endif

  assign acc = in_valid & in_ready;
  assign rel = vld_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= EMPTY;
      vld_q      <= 1'b0;
      cnt_q      <= 2'd0;
      hd_wd_q    <= '0;
      hd_wreg_q  <= 1'b0;
      hd_wdata_q <= '0;
`ifdef PIPE_SKID_EN
      rdy_q      <= 1'b1;
      sk_wd_q    <= '0;
      sk_wreg_q  <= 1'b0;
      sk_wdata_q <= '0;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_q    <= ONE;
            vld_q      <= 1'b1;
            cnt_q      <= 2'd1;
            hd_wd_q    <= in_wd;
            hd_wreg_q  <= in_wreg;
            hd_wdata_q <= in_wdata;
          end
        end
        ONE: begin
          if (acc && rel) begin
            hd_wd_q    <= in_wd;
            hd_wreg_q  <= in_wreg;
            hd_wdata_q <= in_wdata;
          end else if (rel) begin
            state_q    <= EMPTY;
            vld_q      <= 1'b0;
            cnt_q      <= 2'd0;
            hd_wd_q    <= '0;
            hd_wreg_q  <= 1'b0;
            hd_wdata_q <= '0;
`ifdef PIPE_SKID_EN
          end else if (acc) begin
            state_q    <= TWO;
            cnt_q      <= 2'd2;
            rdy_q      <= 1'b0;
            sk_wd_q    <= in_wd;
            sk_wreg_q  <= in_wreg;
            sk_wdata_q <= in_wdata;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          // Skid entry moves up to head as the old head leaves.
          if (rel) begin
            state_q    <= ONE;
            cnt_q      <= 2'd1;
            rdy_q      <= 1'b1;
            hd_wd_q    <= sk_wd_q;
            hd_wreg_q  <= sk_wreg_q;
            hd_wdata_q <= sk_wdata_q;
            sk_wd_q    <= '0;
            sk_wreg_q  <= 1'b0;
            sk_wdata_q <= '0;
          end
        end
`endif
        default: begin
          state_q    <= EMPTY;
          vld_q      <= 1'b0;
          cnt_q      <= 2'd0;
          hd_wd_q    <= '0;
          hd_wreg_q  <= 1'b0;
          hd_wdata_q <= '0;
        end
      endcase
    end
  end

  assign out_valid = vld_q;
  assign out_wd    = hd_wd_q;
  assign out_wreg  = hd_wreg_q;
  assign out_wdata = hd_wdata_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; covers default and skid builds.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_wd;
  logic        out_wreg;
  logic [31:0] out_wdata;
  logic [1:0]  count;

  int passed = 0;
  int total  = 0;

  pipe_stage_reg #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v,
                          input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdata, input logic [1:0] c);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".wd"},    64'(out_wd),    64'(wd));
    chk({tag, ".wreg"},  64'(out_wreg),  64'(wr));
    chk({tag, ".wdata"}, 64'(out_wdata), 64'(wdata));
    chk({tag, ".count"}, 64'(count),     64'(c));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_wd = 5'd3; in_wreg = 1'b1; in_wdata = 32'h99;
    out_ready = 1'b1;
    #2;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_head("reset", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    // streaming
    in_valid = 1'b1; out_ready = 1'b1; in_wd = 5'd1; in_wreg = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_wdata = 32'(i);
      step();
      chk_head("stream", 1'b1, 5'd1, 1'b1, 32'(i), 2'd1);
    end
    in_valid = 1'b0;
    step();
    chk_head("drain", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);

    // stall
    in_valid = 1'b1; in_wd = 5'd5; in_wreg = 1'b1; in_wdata = 32'hAA;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_wdata = 32'hBB; in_wd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      chk_head("stall", 1'b1, 5'd5, 1'b1, 32'hAA, 2'd1);
`ifdef PIPE_SKID_EN
      chk("stall.in_ready", 64'(in_ready), 64'd1);
`else
      chk("stall.in_ready", 64'(in_ready), 64'd0);
`endif
      step();
    end
    chk_head("stall_end", 1'b1, 5'd5, 1'b1, 32'hAA, 2'd1);
    out_ready = 1'b1;
    step();
    chk_head("stall_rel", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);

    // second entry: skid holds it, single-entry build back-pressures
    in_valid = 1'b1; in_wd = 5'd2; in_wreg = 1'b0;
    in_wdata = 32'h10; out_ready = 1'b0;
    step();
    chk_head("skid1", 1'b1, 5'd2, 1'b0, 32'h10, 2'd1);
    in_wdata = 32'h20; in_wd = 5'd4;
`ifdef PIPE_SKID_EN
    step();
    chk_head("skid2", 1'b1, 5'd2, 1'b0, 32'h10, 2'd2);
    chk("skid2.in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_head("skid_pop1", 1'b1, 5'd4, 1'b0, 32'h20, 2'd1);
    chk("skid_pop1.in_ready", 64'(in_ready), 64'd1);
`else
    chk("bp.in_ready", 64'(in_ready), 64'd0);
    step();
    chk_head("bp_hold", 1'b1, 5'd2, 1'b0, 32'h10, 2'd1);
    in_valid = 1'b0; out_ready = 1'b1;
`endif
    step();
    chk_head("skid_pop2", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);

    // flush with an offered entry
    in_valid = 1'b1; in_wd = 5'd7; in_wreg = 1'b1; in_wdata = 32'h11;
    out_ready = 1'b0;
    step();
`ifdef PIPE_SKID_EN
    in_wdata = 32'h22;
    step();
    chk("pre_flush.count", 64'(count), 64'd2);
    in_wdata = 32'h30; flush = 1'b1;
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'd0);
`else
    in_wdata = 32'h30; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'd1);
`endif
    step();
    chk_head("flush", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_head("post_flush", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);

    // simultaneous accept and release
    in_valid = 1'b1; in_wd = 5'd8; in_wreg = 1'b1; in_wdata = 32'h40;
    out_ready = 1'b0;
    step();
    chk_head("sim_head", 1'b1, 5'd8, 1'b1, 32'h40, 2'd1);
    in_wd = 5'd9; in_wreg = 1'b0; in_wdata = 32'h50; out_ready = 1'b1;
    #1;
    chk("sim.in_ready", 64'(in_ready), 64'd1);
    step();
    chk_head("sim_new", 1'b1, 5'd9, 1'b0, 32'h50, 2'd1);
    in_valid = 1'b0;
    step();
    chk_head("sim_drain", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);

    // reset mid-transfer beats a concurrent flush
    in_valid = 1'b1; in_wd = 5'd6; in_wdata = 32'h77; out_ready = 1'b0;
    step();
    chk("mid.wdata", 64'(out_wdata), 64'h77);
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    chk_head("mid_rst", 1'b0, 5'd0, 1'b0, 32'h0, 2'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
